// File: rtl/tfp_pkg.sv
// -----------------------------------------------------------------------------
// tfp_pkg
// Shared definitions for the trivial float-point (TFP) encode/decode blocks.
// A TFP word is {mantissa, exponent}: the mantissa is a signed MW-bit field,
// the exponent an unsigned EXP_WIDTH-bit left-shift count.
//
// Contents:
//   tfp_mant_width  - mantissa width for a given TFP/exponent split
//   tfp_fix_width   - widest signed fixed-point word a TFP format can cover
//   fix2tfp_state_t - encoder FSM states
// -----------------------------------------------------------------------------
package tfp_pkg;

    function automatic int tfp_mant_width(input int tfp_width, input int exp_width);
        return tfp_width - exp_width;
    endfunction

    // The largest exponent shifts the mantissa left by 2**EXP_WIDTH-1 places,
    // so the fixed-point side needs that many bits on top of the mantissa.
    function automatic int tfp_fix_width(input int tfp_width, input int exp_width);
        return tfp_width - exp_width + (2 ** exp_width) - 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fix2tfp_state_t;

endpackage

// File: rtl/fix2tfp_round.sv
// -----------------------------------------------------------------------------
// fix2tfp_round
// Combinational round-half-up stage for the fixed-point to TFP encoder.
// Adds the last bit shifted out to the truncated mantissa. If that pushes the
// mantissa past the signed maximum, the value is renormalised by bumping the
// exponent (mantissa becomes 2**(MW-2)), or saturated when the exponent is
// already at its maximum.
//
// Ports:
//   mant   in   MW          truncated signed mantissa
//   exp_in in   EXP_WIDTH   exponent after normalisation
//   rbit   in   1           last bit shifted out of the accumulator
//   tfp    out  TFP_WIDTH   rounded {mantissa, exponent}
// -----------------------------------------------------------------------------
module fix2tfp_round
    import tfp_pkg::*;
#(
    parameter int TFP_WIDTH = 8,
    parameter int EXP_WIDTH = 3,
    localparam int MW = tfp_mant_width(TFP_WIDTH, EXP_WIDTH)
) (
    input  logic [MW-1:0]        mant,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic                 rbit,
    output logic [TFP_WIDTH-1:0] tfp
);

    localparam logic [EXP_WIDTH-1:0] EXP_MAX   = '1;
    localparam logic [MW-1:0]        MANT_HALF = MW'(2 ** (MW - 2));
    localparam logic [MW-1:0]        MANT_MAX  = MW'(2 ** (MW - 1) - 1);

    logic [MW:0] sum;
    logic        ovf;

    // A one-bit sign-extended sum flags signed overflow when its top two bits
    // differ; only the positive maximum plus one can trigger it.
    always_comb begin
        sum = {mant[MW-1], mant} + {{MW{1'b0}}, rbit};
        ovf = sum[MW] != sum[MW-1];
        if (!ovf) begin
            tfp = {sum[MW-1:0], exp_in};
        end else if (exp_in != EXP_MAX) begin
            tfp = {MANT_HALF, EXP_WIDTH'(exp_in + EXP_WIDTH'(1))};
        end else begin
            tfp = {MANT_MAX, exp_in};
        end
    end

endmodule

// File: rtl/fix2tfp.sv
// -----------------------------------------------------------------------------
// fix2tfp
// Iterative fixed-point to TFP encoder. A signed FIX_WIDTH word is shifted
// right arithmetically one place per cycle until it fits an MW-bit signed
// mantissa; the shift count becomes the exponent. One word in flight at a time.
//
// Optional feature: define FIX2TFP_ROUND_EN to add a round-half-up cycle
// (fix2tfp_round) after normalisation. Without it the result is truncated
// toward -inf.
//
// Ports:
//   clk       in   1          clock
//   rst_n     in   1          asynchronous reset, active low
//   in_data   in   FIX_WIDTH  signed fixed-point value
//   in_valid  in   1          input word valid
//   in_ready  out  1          encoder idle; accept on in_valid & in_ready
//   out_data  out  TFP_WIDTH  {mantissa, exponent}
//   out_valid out  1          result valid
//   out_ready in   1          downstream accepts on out_valid & out_ready
// -----------------------------------------------------------------------------
module fix2tfp
    import tfp_pkg::*;
#(
    parameter int TFP_WIDTH = 8,
    parameter int EXP_WIDTH = 3,
    localparam int MW        = tfp_mant_width(TFP_WIDTH, EXP_WIDTH),
    localparam int FIX_WIDTH = tfp_fix_width(TFP_WIDTH, EXP_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FIX_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [TFP_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    fix2tfp_state_t state, state_nxt;

    logic [FIX_WIDTH-1:0] acc, acc_nxt;
    logic [EXP_WIDTH-1:0] exp_cnt, exp_nxt;
    logic                 in_ready_nxt;
    logic [TFP_WIDTH-1:0] out_data_nxt;
    logic                 out_valid_nxt;
    logic                 fits;
    logic                 accept;

`ifdef FIX2TFP_ROUND_EN
    logic                 rbit, rbit_nxt;
    logic [TFP_WIDTH-1:0] round_data;

    fix2tfp_round #(
        .TFP_WIDTH (TFP_WIDTH),
        .EXP_WIDTH (EXP_WIDTH)
    ) u_round (
        .mant   (acc[MW-1:0]),
        .exp_in (exp_cnt),
        .rbit   (rbit),
        .tfp    (round_data)
    );
`endif

    // The value fits the mantissa when every bit from the mantissa sign bit
    // upward is a copy of the sign.
    assign fits   = (&acc[FIX_WIDTH-1:MW-1]) || !(|acc[FIX_WIDTH-1:MW-1]);
    assign accept = in_valid && in_ready;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            exp_cnt   <= '0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef FIX2TFP_ROUND_EN
            rbit      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            exp_cnt   <= exp_nxt;
            in_ready  <= in_ready_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
`ifdef FIX2TFP_ROUND_EN
            rbit      <= rbit_nxt;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = NORM;
`ifdef FIX2TFP_ROUND_EN
            NORM:  if (fits) state_nxt = ROUND;
            ROUND: state_nxt = OUT;
`else
            NORM:  if (fits) state_nxt = OUT;
`endif
            OUT:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the datapath and registered outputs. The exponent
    // cannot wrap: any FIX_WIDTH word fits after 2**EXP_WIDTH-1 shifts.
    always_comb begin
        acc_nxt       = acc;
        exp_nxt       = exp_cnt;
        in_ready_nxt  = in_ready;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
`ifdef FIX2TFP_ROUND_EN
        rbit_nxt      = rbit;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt      = in_data;
                    exp_nxt      = '0;
                    in_ready_nxt = 1'b0;
`ifdef FIX2TFP_ROUND_EN
                    rbit_nxt     = 1'b0;
`endif
                end else begin
                    in_ready_nxt = 1'b1;
                end
            end
            NORM: begin
                if (fits) begin
`ifndef FIX2TFP_ROUND_EN
                    out_data_nxt  = {acc[MW-1:0], exp_cnt};
                    out_valid_nxt = 1'b1;
`endif
                end else begin
                    acc_nxt = FIX_WIDTH'($signed(acc) >>> 1);
                    exp_nxt = EXP_WIDTH'(exp_cnt + EXP_WIDTH'(1));
`ifdef FIX2TFP_ROUND_EN
                    rbit_nxt = acc[0];
`endif
                end
            end
`ifdef FIX2TFP_ROUND_EN
            ROUND: begin
                out_data_nxt  = round_data;
                out_valid_nxt = 1'b1;
            end
`endif
            OUT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fix2tfp.sv
// -----------------------------------------------------------------------------
// tb_fix2tfp
// Self-checking bench for fix2tfp at default parameters (MW=5, FIX_WIDTH=12).
// Directed vectors carry hand-computed results; a short random stream is
// checked against a behavioural encoder and, for the truncating build, against
// the decode of the produced TFP word. Expected values follow FIX2TFP_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_fix2tfp;

    logic        clk;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int total_checks;
    int bad_checks;

`ifdef FIX2TFP_ROUND_EN
    localparam int         RL    = 1;
    localparam logic [7:0] E_100 = 8'h6B;
    localparam logic [7:0] E_31  = 8'h42;
`else
    localparam int         RL    = 0;
    localparam logic [7:0] E_100 = 8'h63;
    localparam logic [7:0] E_31  = 8'h79;
`endif

    fix2tfp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Behavioural encoder: shift until the value lies in [-16, 15].
    function automatic logic [7:0] model_encode(input logic [11:0] x);
        int         v;
        int         e;
        int         rb;
        logic [4:0] mant;
        logic [2:0] ex;
        v  = int'($signed(x));
        e  = 0;
        rb = 0;
        while (v > 15 || v < -16) begin
            rb = v & 1;
            v  = v >>> 1;
            e++;
        end
`ifdef FIX2TFP_ROUND_EN
        v = v + rb;
        if (v > 15) begin
            if (e < 7) begin
                v = 8;
                e++;
            end else begin
                v = 15;
            end
        end
`endif
        mant = v[4:0];
        ex   = e[2:0];
        return {mant, ex};
    endfunction

    // One full conversion: offer, check latency and data, then drain.
    task automatic applyStimulus(input string tag, input logic [11:0] value,
                                 input logic [7:0] expected, input int lat);
        int n;
        @(negedge clk);
        in_data   = value;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
        checkOutput({tag, "_lat"}, 32'(n), 32'(lat));
        checkOutput({tag, "_data"}, 32'(out_data), 32'(expected));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_drain"}, {30'd0, in_ready, out_valid}, 32'b10);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] raw;
        logic [11:0] value;
        logic [7:0]  expected;
        int          n;
        int          sh;
        int          dec;
        int          err;
        logic        done;
        logic [7:0]  obs;

        total_checks = 0;
        bad_checks   = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;

        // Reset values, and in_ready one edge after release.
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Zero-shift, extremes, mid values.
        applyStimulus("p5",    12'h005, 8'h28, 1 + RL);
        applyStimulus("m1",    12'hFFF, 8'hF8, 1 + RL);
        applyStimulus("zero",  12'h000, 8'h00, 1 + RL);
        applyStimulus("max",   12'h7FF, 8'h7F, 8 + RL);
        applyStimulus("min",   12'h800, 8'h87, 8 + RL);
        applyStimulus("v100",  12'h064, E_100, 4 + RL);
        applyStimulus("v31",   12'h01F, E_31,  2 + RL);

        // Reset in the middle of normalisation: outputs clear immediately.
        @(negedge clk);
        in_data  = 12'h7FF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_recover", 32'(in_ready), 32'd1);
        applyStimulus("after_rst", 12'h005, 8'h28, 1 + RL);

        // Backpressure: result held, new input ignored while busy.
        @(negedge clk);
        in_data  = 12'h064;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_data = 12'h005;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_data", 32'(out_data), 32'(E_100));
            checkOutput("bp_busy", {30'd0, in_ready, out_valid}, 32'b01);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        @(negedge clk);
        out_ready = 1'b0;

        // Random words with random gaps and random downstream readiness.
        for (int w = 0; w < 24; w++) begin
            raw      = $urandom;
            sh       = $urandom_range(0, 11);
            value    = 12'($signed(raw[11:0]) >>> sh);
            expected = model_encode(value);
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            in_data  = value;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkOutput("rnd_accept", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            n    = 0;
            done = 1'b0;
            while (!done && n < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                    n++;
                end
            end
            checkOutput("rnd_done", 32'(done), 32'd1);
            checkOutput("rnd_data", 32'(out_data), 32'(expected));
`ifndef FIX2TFP_ROUND_EN
            obs = out_data;
            dec = int'($signed(obs[7:3])) <<< obs[2:0];
            err = int'($signed(value)) - dec;
            checkOutput("rnd_decode", 32'(err >= 0 && err < (1 << obs[2:0])), 32'd1);
`endif
            @(posedge clk);
            #1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
